axi4_aw_beat_gen: RTL



---
 rtl/axi4_aw_beat_gen.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/axi4_aw_beat_gen.sv
// rtl/axi4_aw_beat_gen.sv - AXI4 AW beat generator, optional one-entry AW buffer via AXI4_AW_BEAT_GEN_INBUF_EN
module axi4_aw_beat_gen #(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  aw_valid,
    output logic                  aw_ready,
    input  logic [ID_WIDTH-1:0]   aw_id,
    input  logic [ADDR_WIDTH-1:0] aw_addr,
    input  logic [7:0]            aw_len,
    input  logic [1:0]            aw_burst,
    input  logic                  aw_lock,
    input  logic [2:0]            aw_prot,
    output logic                  beat_valid,
    input  logic                  beat_ready,
    output logic [ADDR_WIDTH-1:0] beat_addr,
    output logic [ID_WIDTH-1:0]   beat_id,
    output logic                  beat_lock,
    output logic [2:0]            beat_prot,
    output logic [7:0]            beat_idx,
    output logic                  beat_last,
    output logic                  burst_err
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFFS  = $clog2(BYTES);
    localparam logic [ADDR_WIDTH-1:0] OFFS_MASK = ADDR_WIDTH'(BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] STEP      = ADDR_WIDTH'(BYTES);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic {S_IDLE, S_BURST} state_t;

    // burst field holds the effective type: illegal bursts are stored as INCR
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            len;
        logic [1:0]            burst;
        logic [ID_WIDTH-1:0]   id;
        logic                  lock;
        logic [2:0]            prot;
    } aw_req_t;

    function automatic logic is_illegal(input logic [1:0] burst, input logic [7:0] len);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (burst == 2'b11) || ((burst == BURST_WRAP) && !wrap_len_ok);
    endfunction

    state_t                state_q, state_d;
    aw_req_t               cur_q;
    aw_req_t               aw_in;
    logic [7:0]            idx_q;
    logic                  err_q;
    logic                  rdy_en_q;
    logic                  ready_int;
    logic                  aw_hs;
    logic                  beat_hs;
    logic                  burst_done;
    logic                  load_new;
    logic                  load_pend;
    logic [ADDR_WIDTH-1:0] aligned;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [ADDR_WIDTH-1:0] next_addr;

    assign aw_hs      = aw_valid && aw_ready;
    assign beat_hs    = beat_valid && beat_ready;
    assign burst_done = beat_hs && beat_last;

    // Capture of the incoming AW with its burst type already legalised
    always_comb begin
        aw_in       = '0;
        aw_in.addr  = aw_addr;
        aw_in.len   = aw_len;
        aw_in.burst = is_illegal(aw_burst, aw_len) ? BURST_INCR : aw_burst;
        aw_in.id    = aw_id;
        aw_in.lock  = aw_lock;
        aw_in.prot  = aw_prot;
    end

`ifdef AXI4_AW_BEAT_GEN_INBUF_EN
    logic    pend_q;
    aw_req_t pend_req_q;

    // With a pending slot, an AW goes straight to the burst only when the
    // generator is idle or is finishing with nothing already queued.
    assign ready_int = !pend_q;
    assign load_new  = aw_hs && ((state_q == S_IDLE) || (burst_done && !pend_q));
    assign load_pend = burst_done && pend_q;

    // One-entry pending AW register, filled mid-burst and drained at burst end
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pend_q     <= 1'b0;
            pend_req_q <= '0;
        end else if (aw_hs && (state_q == S_BURST) && !burst_done) begin
            pend_q     <= 1'b1;
            pend_req_q <= aw_in;
        end else if (load_pend) begin
            pend_q     <= 1'b0;
        end
    end
`else
    assign ready_int = (state_q == S_IDLE);
    assign load_new  = aw_hs;
    assign load_pend = 1'b0;
`endif

    // Address of the beat after the current one, by burst type
    always_comb begin
        aligned   = cur_q.addr & ~OFFS_MASK;
        wrap_mask = ((ADDR_WIDTH'(cur_q.len) + ADDR_WIDTH'(1)) << OFFS) - ADDR_WIDTH'(1);
        next_addr = aligned + STEP;
        case (cur_q.burst)
            BURST_FIXED: next_addr = cur_q.addr;
            BURST_WRAP:  next_addr = (cur_q.addr & ~wrap_mask) | ((aligned + STEP) & wrap_mask);
            default:     next_addr = aligned + STEP;
        endcase
    end

    // State register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a finishing burst chains straight into another if one is loaded
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (aw_hs) state_d = S_BURST;
            S_BURST: if (burst_done) state_d = (load_new || load_pend) ? S_BURST : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Burst context, beat counter, error pulse and post-reset ready enable
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cur_q    <= '0;
            idx_q    <= 8'd0;
            err_q    <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            err_q    <= aw_hs && is_illegal(aw_burst, aw_len);
            if (load_new) begin
                cur_q <= aw_in;
                idx_q <= 8'd0;
`ifdef AXI4_AW_BEAT_GEN_INBUF_EN
            end else if (load_pend) begin
                cur_q <= pend_req_q;
                idx_q <= 8'd0;
`endif
            end else if (beat_hs) begin
                if (beat_last) begin
                    idx_q <= 8'd0;
                end else begin
                    cur_q.addr <= next_addr;
                    idx_q      <= idx_q + 8'd1;
                end
            end
        end
    end

    // Outputs decoded from state and registered context
    always_comb begin
        aw_ready   = rdy_en_q && ready_int;
        beat_valid = (state_q == S_BURST);
        beat_addr  = cur_q.addr;
        beat_id    = cur_q.id;
        beat_lock  = cur_q.lock;
        beat_prot  = cur_q.prot;
        beat_idx   = idx_q;
        beat_last  = (idx_q == cur_q.len);
        burst_err  = err_q;
    end

endmodule
